multi_button_debouncer: RTL

Parametrised N-channel successor to the single-button debouncer. Each channel has a 2-FF synchronizer, a configurable input polarity, and separate stable-time thresholds for press and release. Each channel produces a clean level, one-cycle press/release strobes and a one-shot long-press strobe. The block sits between the board push-buttons and the top-level control FSM, replacing per-button debouncer instances.

---
 rtl/multi_button_debouncer.sv | 107 ++++++++++
 1 files changed

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer: per-channel 2-FF synchronizer, polarity select,
// asymmetric press/release stable times, level/press/release strobes and a one-shot long-press strobe.
module multi_button_debouncer #(
  parameter int N_CH          = 4,
  parameter int PRESS_COUNT   = 50000,
  parameter int RELEASE_COUNT = 501,
  parameter int LONG_COUNT    = 25000000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long
);

  localparam int MAX_COUNT = (PRESS_COUNT > RELEASE_COUNT) ? PRESS_COUNT : RELEASE_COUNT;
  localparam int CW        = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_COUNT - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_COUNT - 1);
  // Sync flops reset to the idle pin level so a held button is not seen as pressed during reset.
  localparam logic IDLE_PIN = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic          s1_q, s1_d, s2_q, s2_d, act;
    logic          level_q, level_d, press_q, press_d, release_q, release_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      s1_d      = btn_in[gi];
      s2_d      = s1_q;
      act       = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      cnt_d     = '0;
      if (act != level_q) begin
        if (!level_q && cnt_q == PRESS_LAST) begin
          level_d = 1'b1;
          press_d = 1'b1;
        end else if (level_q && cnt_q == RELEASE_LAST) begin
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        s1_q      <= IDLE_PIN;
        s2_q      <= IDLE_PIN;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        cnt_q     <= cnt_d;
      end
    end

    assign btn_level[gi]   = level_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;

    if (LONG_COUNT > 0) begin : g_long
      localparam int LW = $clog2(LONG_COUNT + 1);
      localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_COUNT);
      localparam logic [LW-1:0] LONG_LAST = LW'(LONG_COUNT - 1);
      logic [LW-1:0] hold_q, hold_d;
      logic          long_q, long_d;

      // Hold count tracks the next level, so it reads 1 in the press cycle and LONG_COUNT when btn_long shows.
      always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (level_d) begin
          hold_d = (hold_q == LONG_MAX) ? hold_q : hold_q + LW'(1);
          long_d = (hold_q == LONG_LAST);
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          long_q <= long_d;
        end
      end

      assign btn_long[gi] = long_q;
    end else begin : g_no_long
      assign btn_long[gi] = 1'b0;
    end
  end

endmodule
